// File: rtl/edge_pkg.sv
// Shared widths and arithmetic helpers for the streaming Sobel edge stage.
package edge_pkg;

    localparam int GRAD_EXTRA = 3;
    localparam int MAG_EXTRA  = 4;

    // GRAD_W = PIX_W+3 holds a signed Sobel gradient; MAG_W = PIX_W+4 holds |Gx|+|Gy|.
    function automatic int grad_w(input int pix_w);
        return pix_w + GRAD_EXTRA;
    endfunction

    function automatic int mag_w(input int pix_w);
        return pix_w + MAG_EXTRA;
    endfunction

    function automatic logic [31:0] pix_max(input int pix_w);
        return (32'd1 << pix_w) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_shift(input logic [31:0] mag,
                                              input int unsigned shift,
                                              input logic [31:0] max_val);
        logic [31:0] shifted;
        shifted = mag >> shift;
        return (shifted > max_val) ? max_val : shifted;
    endfunction

endpackage

// File: rtl/edge_line_buffer.sv
// Simple dual-port line RAM: synchronous read that returns the old word when the
// same address is written in the same cycle. Contents are never reset.
module edge_line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              Clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge Clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/edge_sobel_stream.sv
// Streaming 3x3 Sobel magnitude with two line buffers and a 3-stage pipeline.
// Binary thresholding (Mode/Threshold) is built only when EDGE_THRESH_EN is defined.
module edge_sobel_stream
    import edge_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int MAX_W = 512,
    parameter int COL_W = 9,
    parameter int SHIFT = 2
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic [PIX_W-1:0] PixelIn,
    input  logic             ValidIn,
    input  logic             FrameIn,
    input  logic             LineIn,
    input  logic [COL_W-1:0] Width,
    input  logic [PIX_W-1:0] Threshold,
    input  logic             Mode,
    output logic [PIX_W-1:0] PixelOut,
    output logic             ValidOut,
    output logic             FrameOut,
    output logic             LineOut
);

    localparam int               GRAD_W    = grad_w(PIX_W);
    localparam int               MAG_W     = mag_w(PIX_W);
    localparam logic [31:0]      PIX_MAX   = pix_max(PIX_W);
    localparam logic [COL_W:0]   MAX_W_EXT = (COL_W+1)'(MAX_W);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(MAX_W - 1);
    localparam logic [COL_W-1:0] ROW_SAT   = '1;

    // Position counters; row/col_d describe the pixel currently on PixelIn.
    logic [COL_W-1:0] row_q, row_d, col_q, col_d;
    logic [COL_W:0]   width_q, width_d, width_in;
    logic             active_q, active_d;
    logic             mask_in;

    always_comb begin
        row_d    = row_q;
        col_d    = col_q;
        width_d  = width_q;
        active_d = active_q;
        width_in = {1'b0, Width};
        if (ValidIn) begin
            if (FrameIn) begin
                row_d    = '0;
                col_d    = '0;
                width_d  = (width_in > MAX_W_EXT) ? MAX_W_EXT : width_in;
                active_d = 1'b1;
            end else if (LineIn) begin
                row_d = (row_q == ROW_SAT) ? row_q : row_q + 1'b1;
                col_d = '0;
            end else begin
                col_d = (col_q == COL_LAST) ? col_q : col_q + 1'b1;
            end
        end
        mask_in = !active_d || (row_d < COL_W'(2)) || (col_d < COL_W'(2)) ||
                  ({1'b0, col_d} >= width_d) || (width_d < (COL_W+1)'(3));
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            row_q    <= '0;
            col_q    <= '0;
            width_q  <= '0;
            active_q <= 1'b0;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            width_q  <= width_d;
            active_q <= active_d;
        end
    end

    logic [PIX_W-1:0] rd_row1, rd_row2;
    logic             s1_valid_q, s1_frame_q, s1_line_q, s1_mask_q;
    logic [PIX_W-1:0] s1_pix_q;
    logic [COL_W-1:0] s1_col_q;

    edge_line_buffer #(.DATA_W(PIX_W), .DEPTH(MAX_W), .ADDR_W(COL_W)) u_buf_row1 (
        .Clk       (Clk),
        .wr_en_i   (ValidIn),
        .wr_addr_i (col_d),
        .wr_data_i (PixelIn),
        .rd_en_i   (ValidIn),
        .rd_addr_i (col_d),
        .rd_data_o (rd_row1)
    );

    // The row-1 word read one cycle earlier moves down into the row-2 buffer.
    edge_line_buffer #(.DATA_W(PIX_W), .DEPTH(MAX_W), .ADDR_W(COL_W)) u_buf_row2 (
        .Clk       (Clk),
        .wr_en_i   (s1_valid_q),
        .wr_addr_i (s1_col_q),
        .wr_data_i (rd_row1),
        .rd_en_i   (ValidIn),
        .rd_addr_i (col_d),
        .rd_data_o (rd_row2)
    );

    // Window columns, index 0 = row-2 (top) .. 2 = current row (bottom).
    logic [PIX_W-1:0] win0_q [3];
    logic [PIX_W-1:0] win1_q [3];
    logic [PIX_W-1:0] live [3];

    always_comb begin
        live[0] = rd_row2;
        live[1] = rd_row1;
        live[2] = s1_pix_q;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            s1_valid_q <= 1'b0;
            s1_frame_q <= 1'b0;
            s1_line_q  <= 1'b0;
            s1_mask_q  <= 1'b1;
            s1_pix_q   <= '0;
            s1_col_q   <= '0;
            win0_q     <= '{default: '0};
            win1_q     <= '{default: '0};
        end else begin
            s1_valid_q <= ValidIn;
            s1_frame_q <= ValidIn & FrameIn;
            s1_line_q  <= ValidIn & LineIn;
            if (ValidIn) begin
                s1_pix_q  <= PixelIn;
                s1_col_q  <= col_d;
                s1_mask_q <= mask_in;
                win0_q    <= win1_q;
                win1_q    <= live;
            end
        end
    end

    function automatic logic [GRAD_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b,
                                               input logic [PIX_W-1:0] c);
        return GRAD_W'(a) + (GRAD_W'(b) << 1) + GRAD_W'(c);
    endfunction

    logic [GRAD_W-1:0] gx, gy, abs_gx_d, abs_gy_d, abs_gx_q, abs_gy_q;
    logic              s2_valid_q, s2_frame_q, s2_line_q, s2_mask_q;

    always_comb begin
        gx       = wsum(live[0], live[1], live[2]) - wsum(win0_q[0], win0_q[1], win0_q[2]);
        gy       = wsum(win0_q[2], win1_q[2], live[2]) - wsum(win0_q[0], win1_q[0], live[0]);
        abs_gx_d = gx[GRAD_W-1] ? -gx : gx;
        abs_gy_d = gy[GRAD_W-1] ? -gy : gy;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            s2_valid_q <= 1'b0;
            s2_frame_q <= 1'b0;
            s2_line_q  <= 1'b0;
            s2_mask_q  <= 1'b1;
            abs_gx_q   <= '0;
            abs_gy_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_frame_q <= s1_frame_q;
            s2_line_q  <= s1_line_q;
            if (s1_valid_q) begin
                s2_mask_q <= s1_mask_q;
                abs_gx_q  <= abs_gx_d;
                abs_gy_q  <= abs_gy_d;
            end
        end
    end

    logic [MAG_W-1:0] mag;
    logic [PIX_W-1:0] res, edge_val, pix_d, pix_q;
    logic             valid_q, frame_q, line_q;

`ifdef EDGE_THRESH_EN
    always_comb begin
        mag      = MAG_W'(abs_gx_q) + MAG_W'(abs_gy_q);
        res      = PIX_W'(sat_shift(32'(mag), SHIFT, PIX_MAX));
        edge_val = res;
        if (Mode) begin
            edge_val = (res >= Threshold) ? '1 : '0;
        end
        pix_d = (s2_valid_q && !s2_mask_q) ? edge_val : '0;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{Mode, Threshold};

    always_comb begin
        mag      = MAG_W'(abs_gx_q) + MAG_W'(abs_gy_q);
        res      = PIX_W'(sat_shift(32'(mag), SHIFT, PIX_MAX));
        edge_val = res;
        pix_d    = (s2_valid_q && !s2_mask_q) ? edge_val : '0;
    end
`endif

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            pix_q   <= '0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            line_q  <= 1'b0;
        end else begin
            pix_q   <= pix_d;
            valid_q <= s2_valid_q;
            frame_q <= s2_frame_q;
            line_q  <= s2_line_q;
        end
    end

    assign PixelOut = pix_q;
    assign ValidOut = valid_q;
    assign FrameOut = frame_q;
    assign LineOut  = line_q;

endmodule

// File: tb/tb_edge_sobel_stream.sv
// Bench for edge_sobel_stream: two instances (SHIFT=2 and SHIFT=0) share one
// stimulus stream; each image vector carries its hand-computed edge value.
module tb_edge_sobel_stream;

    logic       Clk = 1'b0;
    logic       nReset = 1'b1;
    logic [7:0] PixelIn = '0;
    logic       ValidIn = 1'b0;
    logic       FrameIn = 1'b0;
    logic       LineIn = 1'b0;
    logic [8:0] Width = 9'd8;
    logic [7:0] Threshold = '0;
    logic       Mode = 1'b0;

    logic [7:0] pix_s2, pix_s0;
    logic       vout_s2, vout_s0, fout_s2, fout_s0, lout_s2, lout_s0;

    int n_checks = 0;
    int n_fail = 0;
    int cycle_cnt = 0;
    int valid_cnt = 0;
    bit mon_en = 1'b0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cycle_cnt <= cycle_cnt + 1;

    edge_sobel_stream #(.PIX_W(8), .MAX_W(512), .COL_W(9), .SHIFT(2)) dut_s2 (
        .Clk(Clk), .nReset(nReset), .PixelIn(PixelIn), .ValidIn(ValidIn),
        .FrameIn(FrameIn), .LineIn(LineIn), .Width(Width), .Threshold(Threshold),
        .Mode(Mode), .PixelOut(pix_s2), .ValidOut(vout_s2), .FrameOut(fout_s2),
        .LineOut(lout_s2)
    );

    edge_sobel_stream #(.PIX_W(8), .MAX_W(512), .COL_W(9), .SHIFT(0)) dut_s0 (
        .Clk(Clk), .nReset(nReset), .PixelIn(PixelIn), .ValidIn(ValidIn),
        .FrameIn(FrameIn), .LineIn(LineIn), .Width(Width), .Threshold(Threshold),
        .Mode(Mode), .PixelOut(pix_s0), .ValidOut(vout_s0), .FrameOut(fout_s0),
        .LineOut(lout_s0)
    );

    typedef struct {
        string      name;
        logic [7:0] a, b;
        bit         horiz;
        int         width, len, rows;
        bit         gap;
        bit         mode;
        logic [7:0] thr;
        logic [7:0] exp_s2, exp_s0;
    } vec_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  pa;
        logic [7:0]  pb;
        logic        fr;
        logic        ln;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle_cnt);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [7:0] a, input logic [7:0] b,
                                input bit horiz, input int width, input int len,
                                input int rows, input bit gap, input bit mode,
                                input logic [7:0] thr, input logic [7:0] e2,
                                input logic [7:0] e0);
        vec_t v;
        v.name = name; v.a = a; v.b = b; v.horiz = horiz; v.width = width;
        v.len = len; v.rows = rows; v.gap = gap; v.mode = mode; v.thr = thr;
        v.exp_s2 = e2; v.exp_s0 = e0;
        return v;
    endfunction

    // Scoreboard: each expected output is due exactly 3 cycles after its input.
    always @(negedge Clk) begin
        exp_t e;
        bit   due;
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cycle_cnt) begin
                check("output_missing", 0, 1);
                void'(exp_q.pop_front());
            end
            due = (exp_q.size() > 0) && (exp_q[0].cyc == cycle_cnt);
            check("valid_s2", vout_s2, due);
            check("valid_s0", vout_s0, due);
            if (vout_s2) valid_cnt++;
            if (due) begin
                e = exp_q.pop_front();
                check("pixel_s2", pix_s2, e.pa);
                check("pixel_s0", pix_s0, e.pb);
                check("frame_out", fout_s2, e.fr);
                check("line_out", lout_s2, e.ln);
                check("frame_out_s0", fout_s0, e.fr);
                check("line_out_s0", lout_s0, e.ln);
            end
        end
    end

    task automatic idle(input int n);
        ValidIn = 1'b0; FrameIn = 1'b0; LineIn = 1'b0;
        repeat (n) begin
            @(posedge Clk); #1;
        end
    endtask

    task automatic drive_pixel(input logic [7:0] pix, input bit fr, input bit ln,
                               input logic [7:0] ea, input logic [7:0] eb);
        exp_t e;
        PixelIn = pix; ValidIn = 1'b1; FrameIn = fr; LineIn = ln;
        e.cyc = cycle_cnt + 3; e.pa = ea; e.pb = eb; e.fr = fr; e.ln = ln;
        exp_q.push_back(e);
        @(posedge Clk); #1;
        ValidIn = 1'b0; FrameIn = 1'b0; LineIn = 1'b0;
    endtask

    // Step image: vertical step between cols 3/4, or horizontal step between rows 2/3.
    task automatic drive_img(input vec_t v, input int r, input int c, input bit in_frame);
        logic [7:0] pix, ea, eb;
        bit         on_edge, open;
        pix     = v.horiz ? ((r >= 3) ? v.b : v.a) : ((c >= 4) ? v.b : v.a);
        on_edge = v.horiz ? (r == 3 || r == 4) : (c == 4 || c == 5);
        open    = in_frame && r >= 2 && c >= 2 && c < v.width && v.width >= 3;
        ea = (on_edge && open) ? v.exp_s2 : 8'd0;
        eb = (on_edge && open) ? v.exp_s0 : 8'd0;
        if (v.gap) idle(1);
        drive_pixel(pix, in_frame && r == 0 && c == 0, c == 0, ea, eb);
    endtask

    task automatic run_vec(input vec_t v);
        int cnt0;
        Width = 9'(v.width); Mode = v.mode; Threshold = v.thr;
        cnt0 = valid_cnt;
        for (int r = 0; r < v.rows; r++)
            for (int c = 0; c < v.len; c++)
                drive_img(v, r, c, 1'b1);
        idle(6);
        check({"valid_count ", v.name}, valid_cnt - cnt0, v.rows * v.len);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " pix_s2"}, pix_s2, 0);
        check({tag, " valid_s2"}, vout_s2, 0);
        check({tag, " frame_s2"}, fout_s2, 0);
        check({tag, " line_s2"}, lout_s2, 0);
        check({tag, " pix_s0"}, pix_s0, 0);
        check({tag, " valid_s0"}, vout_s0, 0);
        check({tag, " frame_s0"}, fout_s0, 0);
        check({tag, " line_s0"}, lout_s0, 0);
    endtask

    initial begin
        vec_t v;

        // name, a, b, horiz, width, len, rows, gap, mode, thr, exp SHIFT=2, exp SHIFT=0
        vecs.push_back(mk("flat100",      100, 100, 0, 8, 8,  6, 0, 0, 0,   0,   0));
        vecs.push_back(mk("vstep0_200",     0, 200, 0, 8, 8,  6, 0, 0, 0, 200, 255));
        vecs.push_back(mk("vstep0_255",     0, 255, 0, 8, 8,  5, 0, 0, 0, 255, 255));
        vecs.push_back(mk("vstep200_0",   200,   0, 0, 8, 8,  5, 0, 0, 0, 200, 255));
        vecs.push_back(mk("vstep10_30",    10,  30, 0, 8, 8,  4, 1, 0, 0,  20,  80));
        vecs.push_back(mk("hstep_wide",    50,  90, 1, 8, 10, 6, 0, 0, 0,  40, 160));
        vecs.push_back(mk("width2",         0, 200, 0, 2, 8,  4, 0, 0, 0,   0,   0));
        vecs.push_back(mk("vstep_toggle",   0, 200, 0, 8, 8,  6, 1, 0, 0, 200, 255));
`ifdef EDGE_THRESH_EN
        vecs.push_back(mk("bin_thr150",     0, 100, 0, 8, 8,  4, 0, 1, 150,   0, 255));
        vecs.push_back(mk("bin_thr100",     0, 100, 0, 8, 8,  4, 1, 1, 100, 255, 255));
`else
        vecs.push_back(mk("mode_ignored",   0, 100, 0, 8, 8,  4, 0, 1, 150, 100, 255));
`endif

        // Clock/reset
        #2 nReset = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(posedge Clk);
        #1 nReset = 1'b1;
        idle(2);
        check_outputs_zero("post_reset");
        mon_en = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Reset in the middle of row 3 while pixels are still in flight.
        v = mk("after_reset", 0, 200, 0, 8, 8, 6, 0, 0, 0, 200, 255);
        Width = 9'd8; Mode = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < ((r < 3) ? 8 : 4); c++)
                drive_img(v, r, c, 1'b1);
        while (exp_q.size() > 0 && exp_q[$].cyc >= cycle_cnt) void'(exp_q.pop_back());
        nReset = 1'b0;
        #1 check_outputs_zero("mid_reset");
        repeat (3) @(posedge Clk);
        #1 check_outputs_zero("mid_reset_hold");
        nReset = 1'b1;
        idle(2);

        // Lines before the next FrameIn pass through as zeros.
        for (int r = 1; r < 4; r++)
            for (int c = 0; c < 8; c++)
                drive_img(v, r, c, 1'b0);
        idle(6);

        run_vec(v);

        idle(4);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_sobel_stream.md
# edge_sobel_stream

Parametrised streaming Sobel edge detector, the next generation of the pixel-pipeline edge stage. It takes a raster pixel stream with frame and line markers and computes a true 3x3 Sobel magnitude |Gx|+|Gy| using two internal line buffers. It produces one output pixel per valid input pixel, with optional binary thresholding. It sits between the capture/preprocess stage and the Hough accumulator.

## Interface
Parameters:
- PIX_W, 8: pixel bit width.
- MAX_W, 512: maximum line width in pixels; sets line buffer depth.
- COL_W, 9: column counter/Width width, clog2(MAX_W).
- SHIFT, 2: right shift applied to the raw magnitude before saturation.

Ports:
- Clk  in  1  clock.
- nReset  in  1  reset, asynchronous, active-low.
- PixelIn  in  PIX_W  input pixel.
- ValidIn  in  1  PixelIn/FrameIn/LineIn qualifier.
- FrameIn  in  1  first pixel of frame (qualified).
- LineIn  in  1  first pixel of line (qualified).
- Width  in  COL_W  active line width; sampled on FrameIn.
- Threshold  in  PIX_W  binary-mode threshold.
- Mode  in  1  0 = magnitude, 1 = binary.
- PixelOut  out  PIX_W  edge result.
- ValidOut  out  1  PixelOut qualifier.
- FrameOut  out  1  delayed FrameIn.
- LineOut  out  1  delayed LineIn.

## Operation
- No backpressure. The pipeline advances every cycle. Cycles with ValidIn=0 become ValidOut=0 bubbles, and the window and counters hold during them.
- Counters:
  - FrameIn&ValidIn: row=0, col=0, latch Width.
  - LineIn&ValidIn without FrameIn: row++ (saturating), col=0.
  - Otherwise each valid pixel does col++, saturating at MAX_W-1.
  - FrameIn and LineIn together: FrameIn wins.
- Line buffers: two buffers, each MAX_W x PIX_W. At each valid pixel, address col is read from both, the row-1 value is written into the row-2 buffer, and PixelIn is written into the row-1 buffer.
- Window: 3x3 shift register of columns {row-2, row-1, row}, shifted per valid pixel. The window's bottom-right pixel is the current input.
- Arithmetic:
  - Gx = (p02+2p12+p22)-(p00+2p10+p20), signed PIX_W+3 bits.
  - Gy = (p20+2p21+p22)-(p00+2p01+p02), signed PIX_W+3 bits.
  - mag = |Gx|+|Gy|, unsigned PIX_W+4 bits.
  - res = min(mag>>SHIFT, 2^PIX_W-1).
- Border masking: res is forced to 0 when row<2, col<2, col>=latched Width, or latched Width<3. A latched Width above MAX_W is clamped to MAX_W.
- Mode=1: PixelOut = (res >= Threshold) ? all-ones : 0. Masked pixels output 0.
- Reset mid-frame: counters, window, pipeline and outputs are cleared. Line buffer contents are not cleared; border masking hides the stale data. The stream resumes at the next FrameIn. Pixels arriving before that FrameIn are passed through with PixelOut=0.

## Timing
- Reset values: PixelOut=0, ValidOut=0, FrameOut=0, LineOut=0.
- Fixed latency of 3 Clk cycles from the ValidIn sample to ValidOut:
  - S1: buffer read and window shift.
  - S2: Gx/Gy and abs.
  - S3: sum, shift, saturate, threshold, output register.
- FrameOut and LineOut are ValidIn-qualified markers delayed by exactly 3 cycles, coincident with their pixel's ValidOut.
- Output count equals input count. PixelOut at input position (r,c) is the Sobel result of the window centred at (r-1,c-1).
- Mode and Threshold are sampled in S3 and may change on any cycle.

## Configuration
- EDGE_THRESH_EN defined: binary thresholding is available via Mode and Threshold.
- Undefined: the threshold comparator is not built, Mode and Threshold are ignored, and PixelOut is always the magnitude res.

## Structure
- Package edge_pkg holds:
  - derived widths: GRAD_W = PIX_W+3 and MAG_W = PIX_W+4;
  - the pixel-max constant;
  - a saturate-and-shift function.
- Sub-module edge_line_buffer: simple dual-port RAM with synchronous read and write-first-irrelevant addressing (read and write to the same address in one cycle return the old data). It is instantiated twice.

## Test plan
- Flat image, Width=8, 6 lines all 100 -> every PixelOut=0, ValidOut count 48, FrameOut/LineOut 3 cycles after their inputs.
- Vertical step, Width=8, cols 0-3=0, cols 4-7=200, SHIFT=2 -> rows 0-1 all 0; rows >=2 give 200 at cols 4,5 and 0 elsewhere.
- Step 0->255 with SHIFT=0 -> raw 1020 saturates, PixelOut=255 at cols 4,5.
- EDGE_THRESH_EN, Mode=1, Threshold=150, step 0->100 (res=100) -> all 0. Threshold=100 -> 255 at cols 4,5.
- Same step image with ValidIn toggling every other cycle -> identical PixelOut sequence on ValidOut, with bubbles preserved.
- nReset pulsed mid-row-3, then a new frame -> outputs 0 during reset, rows 0-1 of the new frame 0, then correct results.
